traffic_phase_scheduler: RTL and testbench

- Sequences the four-way intersection: decides which road (A-D) gets right-of-way, and for how long, from per-road vehicle-sensor requests and an emergency-vehicle preempt.
- Drives per-road green/yellow enables plus an all-red indication. Replaces fixed per-road dwell timing with demand-driven, fair round-robin scheduling.
- Sits between the sensor/switch inputs and the lamp drivers.

---
 rtl/traffic_phase_scheduler.sv | 148 ++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// Four-way intersection phase sequencer: demand-driven round-robin green grants
// with minimum/maximum green, fixed yellow and all-red clearance, and emergency preempt.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 12,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] veh_req,
  input  logic       emg_req,
  input  logic [1:0] emg_road,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic       all_red,
  output logic [1:0] active_road
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    ALL_RED = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic [1:0]       road_nx;
  logic [1:0]       grant;
  logic [1:0]       cand;
  logic             found;
  logic [3:0]       req_rd;
  logic             any_req;
  logic             others;
  logic             emg_hold;
  logic             emg_other;

  function automatic logic [3:0] lamp(input logic [1:0] r);
    lamp = 4'b1000 >> r;
  endfunction

  // Requests re-indexed by road number (A=0) so road arithmetic indexes directly.
  always_comb begin
    req_rd = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      req_rd[i] = veh_req[3 - i];
    end
  end

  // Round-robin search starts just after the current road; current road is last.
  always_comb begin
    grant = active_road;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = active_road + 2'(k);
      if (!found && req_rd[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
    if (emg_req) begin
      grant = emg_road;
    end
  end

  assign any_req   = emg_req | (|veh_req);
  assign others    = |(req_rd & ~(4'b0001 << active_road));
  assign emg_hold  = emg_req && (emg_road == active_road);
  assign emg_other = emg_req && (emg_road != active_road);

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    road_nx  = active_road;
    unique case (state)
      IDLE: begin
        timer_nx = '0;
        if (any_req) begin
          state_nx = GREEN;
          road_nx  = grant;
        end
      end
      GREEN: begin
        // GREEN_MAX never forces an exit on its own: the min-green rule already
        // fires whenever another road waits, so the timer only needs to saturate.
        if (emg_other || (others && !emg_hold && timer >= GMIN_LAST)) begin
          state_nx = YELLOW;
          timer_nx = '0;
        end else if (timer != GMAX_LAST) begin
          timer_nx = timer + CNT_W'(1);
        end
      end
      YELLOW: begin
        if (timer == YEL_LAST) begin
          state_nx = ALL_RED;
          timer_nx = '0;
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end
      ALL_RED: begin
        if (timer == AR_LAST) begin
          timer_nx = '0;
          if (any_req) begin
            state_nx = GREEN;
            road_nx  = grant;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          timer_nx = timer + CNT_W'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Lamp registers are loaded from the next-state decode so they track state exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      active_road <= 2'd3;
      green       <= '0;
      yellow      <= '0;
      all_red     <= 1'b1;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      active_road <= road_nx;
      green       <= (state_nx == GREEN)  ? lamp(road_nx) : '0;
      yellow      <= (state_nx == YELLOW) ? lamp(road_nx) : '0;
      all_red     <= (state_nx == IDLE) || (state_nx == ALL_RED);
    end
  end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// each compared against a phase/countdown reference model.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 4;
  localparam int GREEN_MAX = 12;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;

  logic       clk;
  logic       rst;
  logic [3:0] veh_req;
  logic       emg_req;
  logic [1:0] emg_road;
  logic [3:0] green;
  logic [3:0] yellow;
  logic       all_red;
  logic [1:0] active_road;

  int total = 0;
  int bad   = 0;

  // Model: phase 0=idle 1=green 2=yellow 3=all-red; m_n is cycles shown in
  // green, or cycles still to show in yellow / all-red.
  int m_ph   = 0;
  int m_road = 3;
  int m_n    = 0;

  traffic_phase_scheduler #(
    .GREEN_MIN(GREEN_MIN),
    .GREEN_MAX(GREEN_MAX),
    .YELLOW_T (YELLOW_T),
    .ALLRED_T (ALLRED_T),
    .CNT_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .veh_req    (veh_req),
    .emg_req    (emg_req),
    .emg_road   (emg_road),
    .green      (green),
    .yellow     (yellow),
    .all_red    (all_red),
    .active_road(active_road)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit road_wants(input int r);
    logic [3:0] v;
    v = veh_req;
    return v[3 - r];
  endfunction

  function automatic int m_grant();
    if (emg_req) return int'(emg_road);
    for (int k = 1; k <= 4; k++) begin
      if (road_wants((m_road + k) % 4)) return (m_road + k) % 4;
    end
    return m_road;
  endfunction

  task automatic model_step();
    bit any, others, hold, other_emg;
    any = emg_req || (veh_req != 4'b0000);
    if (rst) begin
      m_ph = 0; m_road = 3; m_n = 0;
    end else begin
      case (m_ph)
        0: if (any) begin m_road = m_grant(); m_ph = 1; m_n = 1; end
        1: begin
          others = 0;
          for (int r = 0; r < 4; r++) if (r != m_road && road_wants(r)) others = 1;
          hold      = emg_req && int'(emg_road) == m_road;
          other_emg = emg_req && int'(emg_road) != m_road;
          if (other_emg || (others && !hold && m_n >= GREEN_MIN)) begin
            m_ph = 2; m_n = YELLOW_T;
          end else m_n++;
        end
        2: if (m_n == 1) begin m_ph = 3; m_n = ALLRED_T; end else m_n--;
        default: if (m_n == 1) begin
          if (any) begin m_road = m_grant(); m_ph = 1; m_n = 1; end
          else m_ph = 0;
        end else m_n--;
      endcase
    end
  endtask

  function automatic logic [10:0] exp_vec();
    logic [3:0] g, y;
    g = (m_ph == 1) ? (4'b1000 >> m_road) : 4'b0000;
    y = (m_ph == 2) ? (4'b1000 >> m_road) : 4'b0000;
    return {g, y, (m_ph == 0 || m_ph == 3), 2'(m_road)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; veh_req = '0; emg_req = 1'b0; emg_road = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; veh_req = 4'b1111; emg_req = 1'b1; emg_road = 2'd1;
    tick();
    total++;
    if ({green, yellow, all_red, active_road} !== {4'b0000, 4'b0000, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b", {green, yellow, all_red, active_road},
               {4'b0000, 4'b0000, 1'b1, 2'd3});
    end
    rst = 1'b0; emg_req = 1'b0; veh_req = '0;
  endtask

  task automatic test_single_road();
    do_reset();
    veh_req = 4'b0010;
    for (int i = 1; i <= 20; i++) begin
      tick();
      total++;
      if ({green, active_road, all_red} !== {4'b0010, 2'd2, 1'b0} ||
          {green, yellow, all_red, active_road} !== exp_vec()) begin
        bad++;
        $display("FAIL single_road cyc=%0d got=%b want=%b", i,
                 {green, yellow, all_red, active_road}, exp_vec());
      end
    end
  endtask

  task automatic test_alternate();
    logic [3:0] want_g;
    do_reset();
    veh_req = 4'b1100;
    for (int i = 1; i <= 30; i++) begin
      tick();
      want_g = (i >= 1 && i <= 4) || (i >= 15 && i <= 18) ? 4'b1000 :
               (i >= 8 && i <= 11) ? 4'b0100 : 4'b0000;
      total++;
      if ((i <= 21 && green !== want_g) || {green, yellow, all_red, active_road} !== exp_vec()) begin
        bad++;
        $display("FAIL alternate cyc=%0d got=%b want=%b green_want=%b", i,
                 {green, yellow, all_red, active_road}, exp_vec(), want_g);
      end
    end
  endtask

  task automatic test_late_request();
    do_reset();
    veh_req = 4'b1000;
    tick(); tick();
    veh_req = 4'b1100;
    for (int i = 3; i <= 12; i++) begin
      tick();
      total++;
      if ((i == 4 && green !== 4'b1000) || (i == 5 && yellow !== 4'b1000) ||
          (i == 8 && green !== 4'b0100) ||
          {green, yellow, all_red, active_road} !== exp_vec()) begin
        bad++;
        $display("FAIL late_request cyc=%0d got=%b want=%b", i,
                 {green, yellow, all_red, active_road}, exp_vec());
      end
    end
  endtask

  task automatic test_emg_preempt();
    do_reset();
    veh_req = 4'b1000;
    tick();
    veh_req = 4'b0001; emg_req = 1'b1; emg_road = 2'd2;
    for (int i = 2; i <= 8; i++) begin
      tick();
      total++;
      if ((i == 2 && yellow !== 4'b1000) || (i == 4 && all_red !== 1'b1) ||
          (i == 5 && green !== 4'b0010) ||
          {green, yellow, all_red, active_road} !== exp_vec()) begin
        bad++;
        $display("FAIL emg_preempt cyc=%0d got=%b want=%b", i,
                 {green, yellow, all_red, active_road}, exp_vec());
      end
    end
    emg_req = 1'b0;
  endtask

  task automatic test_emg_hold();
    do_reset();
    veh_req = 4'b1000; emg_req = 1'b1; emg_road = 2'd0;
    tick();
    veh_req = 4'b1100;
    for (int i = 2; i <= 18; i++) begin
      tick();
      total++;
      if (green !== 4'b1000 || {green, yellow, all_red, active_road} !== exp_vec()) begin
        bad++;
        $display("FAIL emg_hold cyc=%0d got=%b want=%b", i,
                 {green, yellow, all_red, active_road}, exp_vec());
      end
    end
    emg_req = 1'b0;
    tick();
    total++;
    if (yellow !== 4'b1000 || {green, yellow, all_red, active_road} !== exp_vec()) begin
      bad++;
      $display("FAIL emg_release got=%b want=%b", {green, yellow, all_red, active_road}, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    int waited;
    do_reset();
    veh_req = 4'b0100;
    tick();
    veh_req = 4'b1100;
    waited = 0;
    while (yellow !== 4'b0100 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if (yellow !== 4'b0100) begin
      bad++;
      $display("FAIL reach_yellow_b got=%b want=%b after %0d cycles", yellow, 4'b0100, waited);
    end
    rst = 1'b1; veh_req = 4'b1111;
    tick();
    total++;
    if ({green, yellow, all_red, active_road} !== {4'b0000, 4'b0000, 1'b1, 2'd3}) begin
      bad++;
      $display("FAIL reset_mid got=%b want=%b", {green, yellow, all_red, active_road},
               {4'b0000, 4'b0000, 1'b1, 2'd3});
    end
    rst = 1'b0;
    tick();
    total++;
    if (green !== 4'b1000 || active_road !== 2'd0) begin
      bad++;
      $display("FAIL after_reset_grant got=%b/%0d want=%b/0", green, active_road, 4'b1000);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) veh_req = 4'($urandom);
      if ($urandom_range(0, 29) == 0) emg_req = ~emg_req;
      if ($urandom_range(0, 9) == 0) emg_road = 2'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      tick();
      total++;
      if ({green, yellow, all_red, active_road} !== exp_vec() ||
          $countones(green | yellow) > 1 || all_red !== ((green | yellow) == 4'b0000)) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b want=%b", i,
                 {green, yellow, all_red, active_road}, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; veh_req = '0; emg_req = 1'b0; emg_road = '0;
    test_reset();
    test_single_road();
    test_alternate();
    test_late_request();
    test_emg_preempt();
    test_emg_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
